top_pipeline: RTL and testbench

Five-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS-subset processor core with internal instruction memory, data memory and register file. It is the top of the processor hierarchy: it starts executing from a caller-supplied start address after reset. Benches observe its state through the debug outputs and the register file contents.

---
 rtl/pipeline_pkg.sv | 111 +++++++++++
 rtl/top_pipeline_regfile.sv | 43 ++++
 rtl/top_pipeline.sv | 184 ++++++++++++++++++
 tb/tb_top_pipeline.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage MIPS-subset pipeline:
// encodings, control word, pipeline-register layouts and the main decoder.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc_plus4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
  } id_ex_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  dst;
  } ex_mem_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  dst;
  } mem_wb_t;

  // Unsupported opcodes and functs fall through to an all-zero control word.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = CTRL_NOP;
    case (instr[31:26])
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (instr[5:0])
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = CTRL_NOP;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/top_pipeline_regfile.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one write port, $0 hardwired to zero.
module regfile
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] registers_i [0:31];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers_i[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      registers_i[wr_addr] <= wr_data;
    end
  end

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data_a = registers_i[rd_addr_a];
    if (rd_addr_a == 5'd0)                          rd_data_a = '0;
    else if (wr_en && (wr_addr == rd_addr_a))       rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = registers_i[rd_addr_b];
    if (rd_addr_b == 5'd0)                          rd_data_b = '0;
    else if (wr_en && (wr_addr == rd_addr_b))       rd_data_b = wr_data;
  end

endmodule

// File: rtl/top_pipeline.sv
// Five-stage IF/ID/EX/MEM/WB MIPS-subset core with internal instruction and
// data memories, full forwarding, load-use stall, beq in EX and j in ID.
module top_pipeline
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_init,
  output logic [31:0] program_counter,
  output logic [31:0] alu_out_exec
);

  logic [31:0] instr_mem [0:255];
  logic [31:0] data_mem  [0:255];

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  // ---------------- IF ----------------
  logic [31:0] fetch_instr;
  logic [31:0] pc_plus4;

  assign fetch_instr = instr_mem[pc_q[9:2]];
  assign pc_plus4    = pc_q + 32'd4;

  // ---------------- ID ----------------
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_val, id_rt_val, id_imm, jump_target;
  ctrl_t       id_ctrl;
  logic        id_jump;

  assign id_rs       = if_id_q.instr[25:21];
  assign id_rt       = if_id_q.instr[20:16];
  assign id_rd       = if_id_q.instr[15:11];
  assign id_imm      = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
  assign id_ctrl     = decode(if_id_q.instr);
  assign id_jump     = (if_id_q.instr[31:26] == OP_J);
  assign jump_target = {if_id_q.pc_plus4[31:28], if_id_q.instr[25:0], 2'b00};

  // ---------------- WB ----------------
  logic [31:0] wb_data;
  logic        wb_en;

  assign wb_data = mem_wb_q.ctrl.mem_to_reg ? mem_wb_q.load_data : mem_wb_q.alu_result;
  assign wb_en   = mem_wb_q.ctrl.reg_write & ~reset;

  regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (id_rs),
    .rd_data_a (id_rs_val),
    .rd_addr_b (id_rt),
    .rd_data_b (id_rt_val),
    .wr_en     (wb_en),
    .wr_addr   (mem_wb_q.dst),
    .wr_data   (wb_data)
  );

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_result, branch_target;
  logic        branch_taken;

  // Youngest producer wins; a zero source never matches, so $0 stays zero.
  always_comb begin
    fwd_a = id_ex_q.rs_val;
    if (id_ex_q.rs != 5'd0) begin
      if (ex_mem_q.ctrl.reg_write && (ex_mem_q.dst == id_ex_q.rs))
        fwd_a = ex_mem_q.alu_result;
      else if (mem_wb_q.ctrl.reg_write && (mem_wb_q.dst == id_ex_q.rs))
        fwd_a = wb_data;
    end
  end

  always_comb begin
    fwd_b = id_ex_q.rt_val;
    if (id_ex_q.rt != 5'd0) begin
      if (ex_mem_q.ctrl.reg_write && (ex_mem_q.dst == id_ex_q.rt))
        fwd_b = ex_mem_q.alu_result;
      else if (mem_wb_q.ctrl.reg_write && (mem_wb_q.dst == id_ex_q.rt))
        fwd_b = wb_data;
    end
  end

  assign alu_b = id_ex_q.ctrl.alu_src ? id_ex_q.imm : fwd_b;

  always_comb begin
    case (id_ex_q.ctrl.alu_op)
      ALU_ADD: alu_result = fwd_a + alu_b;
      ALU_SUB: alu_result = fwd_a - alu_b;
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_result = fwd_a + alu_b;
    endcase
  end

  assign branch_taken  = id_ex_q.ctrl.branch && (fwd_a == fwd_b);
  assign branch_target = id_ex_q.pc_plus4 + {id_ex_q.imm[29:0], 2'b00};

  // ---------------- MEM ----------------
  logic [7:0]  mem_addr;
  logic [31:0] load_data;

  assign mem_addr  = ex_mem_q.alu_result[9:2];
  assign load_data = data_mem[mem_addr];

  // NOTE: memory arrays are deliberately left out of reset; contents survive
  // a core reset and clearing them would need one write port per word.
  always_ff @(posedge clk) begin
    if (!reset && ex_mem_q.ctrl.mem_write)
      data_mem[mem_addr] <= ex_mem_q.store_data;
  end

  // ---------------- hazard detection ----------------
  logic load_use;

  assign load_use = id_ex_q.ctrl.mem_read && (id_ex_q.rt != 5'd0) &&
                    ((id_ex_q.rt == id_rs) || (id_ex_q.rt == id_rt));

  // ---------------- next-state ----------------
  always_comb begin
    pc_d = pc_plus4;

    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.instr    = fetch_instr;

    id_ex_d.ctrl     = id_ctrl;
    id_ex_d.pc_plus4 = if_id_q.pc_plus4;
    id_ex_d.rs_val   = id_rs_val;
    id_ex_d.rt_val   = id_rt_val;
    id_ex_d.imm      = id_imm;
    id_ex_d.rs       = id_rs;
    id_ex_d.rt       = id_rt;
    id_ex_d.dst      = id_ctrl.reg_dst ? id_rd : id_rt;

    ex_mem_d.ctrl       = id_ex_q.ctrl;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.store_data = fwd_b;
    ex_mem_d.dst        = id_ex_q.dst;

    mem_wb_d.ctrl       = ex_mem_q.ctrl;
    mem_wb_d.alu_result = ex_mem_q.alu_result;
    mem_wb_d.load_data  = load_data;
    mem_wb_d.dst        = ex_mem_q.dst;

    if (branch_taken) begin
      pc_d    = branch_target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (id_jump) begin
      pc_d    = jump_target;
      if_id_d = '0;
    end else if (load_use) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  // NOTE: reset is synchronous and active-high: it is only sampled at the
  // rising edge, so it lives inside the clocked if/else, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= pc_init;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign program_counter = pc_q;
  assign alu_out_exec    = alu_result;

endmodule

// File: tb/tb_top_pipeline.sv
// Directed bench for top_pipeline: a table of ALU instructions with
// hand-computed results, plus sequences for stalls, branches, jumps and reset.
module tb_top_pipeline;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_init = 32'd400;
  logic [31:0] program_counter;
  logic [31:0] alu_out_exec;

  top_pipeline dut (
    .clk             (clk),
    .reset           (reset),
    .pc_init         (pc_init),
    .program_counter (program_counter),
    .alu_out_exec    (alu_out_exec)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          dst;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] reg_val(input int idx);
    return dut.u_regfile.registers_i[idx];
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.instr_mem[i] = NOP_INSTR;
  endtask

  task automatic start(input logic [31:0] pc);
    reset   = 1'b1;
    pc_init = pc;
    tick(2);
    reset   = 1'b0;
  endtask

  task automatic check_regs_zero(input string name);
    int nonzero;
    nonzero = 0;
    for (int i = 0; i < 32; i++) if (reg_val(i) !== 32'd0) nonzero++;
    check(name, nonzero, 0);
  endtask

  initial begin
    vecs[0]  = '{"addi_neg",   itype(OP_ADDI, 5'd0, 5'd1, 16'hFFFB), 1,  32'hFFFF_FFFB};
    vecs[1]  = '{"addi_pos",   itype(OP_ADDI, 5'd0, 5'd2, 16'd3),    2,  32'd3};
    vecs[2]  = '{"add",        rtype(5'd1, 5'd2, 5'd3, FN_ADD),       3,  32'hFFFF_FFFE};
    vecs[3]  = '{"sub",        rtype(5'd2, 5'd1, 5'd4, FN_SUB),       4,  32'd8};
    vecs[4]  = '{"and",        rtype(5'd1, 5'd2, 5'd5, FN_AND),       5,  32'd3};
    vecs[5]  = '{"or",         rtype(5'd1, 5'd2, 5'd6, FN_OR),        6,  32'hFFFF_FFFB};
    vecs[6]  = '{"slt_signed", rtype(5'd1, 5'd2, 5'd7, FN_SLT),       7,  32'd1};
    vecs[7]  = '{"slt_false",  rtype(5'd2, 5'd1, 5'd10, FN_SLT),      10, 32'd0};
    vecs[8]  = '{"add_wrap",   rtype(5'd1, 5'd1, 5'd12, FN_ADD),      12, 32'hFFFF_FFF6};
    vecs[9]  = '{"bad_funct",  rtype(5'd1, 5'd2, 5'd13, 6'h21),       13, 32'd0};
    vecs[10] = '{"bad_opcode", itype(6'h3F, 5'd1, 5'd15, 16'd5),      15, 32'd0};

    // Reset state, first fetch and the forwarding chain
    clear_imem();
    dut.instr_mem[100] = itype(OP_ADDI, 5'd0, 5'd20, 16'd10);
    dut.instr_mem[101] = itype(OP_ADDI, 5'd20, 5'd21, 16'd5);
    dut.instr_mem[102] = rtype(5'd20, 5'd20, 5'd19, FN_SUB);
    reset   = 1'b1;
    pc_init = 32'd400;
    tick(2);
    check("reset_pc", program_counter, 32'd400);
    check("reset_alu", alu_out_exec, 32'd0);
    check_regs_zero("reset_regs");
    reset = 1'b0;
    check("first_fetch_pc", program_counter, 32'd400);
    check("post_reset_alu", alu_out_exec, 32'd0);
    tick(1);
    check("second_fetch_pc", program_counter, 32'd404);
    tick(11);
    check("fwd_r19", reg_val(19), 32'd0);
    check("fwd_r20", reg_val(20), 32'd10);
    check("fwd_r21", reg_val(21), 32'd15);
    check("no_stall_pc", program_counter, 32'd448);

    // Table-driven ALU vectors, back-to-back dependent
    clear_imem();
    foreach (vecs[i]) dut.instr_mem[100 + i] = vecs[i].instr;
    start(32'd400);
    tick(20);
    foreach (vecs[i]) check(vecs[i].name, reg_val(vecs[i].dst), vecs[i].exp);

    // Load-use stall
    clear_imem();
    dut.instr_mem[100] = itype(OP_ADDI, 5'd0, 5'd20, 16'd10);
    dut.instr_mem[101] = itype(OP_SW, 5'd0, 5'd20, 16'd0);
    dut.instr_mem[102] = itype(OP_LW, 5'd0, 5'd8, 16'd0);
    dut.instr_mem[103] = rtype(5'd8, 5'd8, 5'd9, FN_ADD);
    start(32'd400);
    tick(4);
    check("lu_pc_c4", program_counter, 32'd416);
    tick(1);
    check("lu_pc_held", program_counter, 32'd416);
    check("lu_bubble_alu", alu_out_exec, 32'd0);
    tick(1);
    check("lu_pc_resume", program_counter, 32'd420);
    check("lu_fwd_load_alu", alu_out_exec, 32'd20);
    tick(6);
    check("lu_r8", reg_val(8), 32'd10);
    check("lu_r9", reg_val(9), 32'd20);

    // Taken beq flushes two, not-taken costs nothing
    clear_imem();
    dut.instr_mem[100] = itype(OP_BEQ, 5'd0, 5'd0, 16'd2);
    dut.instr_mem[101] = itype(OP_ADDI, 5'd0, 5'd22, 16'd1);
    dut.instr_mem[102] = itype(OP_ADDI, 5'd0, 5'd23, 16'd2);
    dut.instr_mem[103] = itype(OP_ADDI, 5'd0, 5'd24, 16'd3);
    dut.instr_mem[104] = itype(OP_BEQ, 5'd24, 5'd0, 16'd5);
    dut.instr_mem[105] = itype(OP_ADDI, 5'd0, 5'd25, 16'd4);
    start(32'd400);
    tick(2);
    check("beq_pc_c2", program_counter, 32'd408);
    tick(1);
    check("beq_target_pc", program_counter, 32'd412);
    tick(5);
    check("beq_nt_pc", program_counter, 32'd432);
    tick(6);
    check("beq_flush_r22", reg_val(22), 32'd0);
    check("beq_flush_r23", reg_val(23), 32'd0);
    check("beq_r24", reg_val(24), 32'd3);
    check("beq_nt_r25", reg_val(25), 32'd4);

    // Jump flushes one; writes to $0 are dropped
    clear_imem();
    dut.instr_mem[100] = {OP_J, 26'd120};
    dut.instr_mem[101] = itype(OP_ADDI, 5'd0, 5'd26, 16'd9);
    dut.instr_mem[120] = itype(OP_ADDI, 5'd0, 5'd0, 16'd7);
    dut.instr_mem[121] = itype(OP_ADDI, 5'd0, 5'd27, 16'd11);
    start(32'd400);
    tick(1);
    check("j_pc_c1", program_counter, 32'd404);
    tick(1);
    check("j_target_pc", program_counter, 32'd480);
    tick(8);
    check("j_r0", reg_val(0), 32'd0);
    check("j_flush_r26", reg_val(26), 32'd0);
    check("j_r27", reg_val(27), 32'd11);

    // Reset mid-program: no stale writeback, data memory retained
    clear_imem();
    dut.instr_mem[100] = itype(OP_ADDI, 5'd0, 5'd28, 16'd5);
    dut.instr_mem[101] = itype(OP_ADDI, 5'd0, 5'd29, 16'd6);
    dut.instr_mem[102] = itype(OP_ADDI, 5'd0, 5'd31, 16'd7);
    dut.instr_mem[150] = itype(OP_LW, 5'd0, 5'd30, 16'd0);
    start(32'd400);
    tick(3);
    reset   = 1'b1;
    pc_init = 32'd600;
    tick(1);
    check("midrst_pc", program_counter, 32'd600);
    check("midrst_alu", alu_out_exec, 32'd0);
    check_regs_zero("midrst_regs");
    reset = 1'b0;
    tick(10);
    check("midrst_r28", reg_val(28), 32'd0);
    check("midrst_r29", reg_val(29), 32'd0);
    check("midrst_r31", reg_val(31), 32'd0);
    check("midrst_dmem_kept", reg_val(30), 32'd10);
    check("midrst_pc_run", program_counter, 32'd640);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
